// File: rtl/eth_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package : eth_pkg                                                        |
// | Purpose : Shared types and constants for the Ethernet receive packer:    |
// |           FSM state encoding, SFD value, minimum frame length and the    |
// |           bit positions of the frame status flags.                       |
// | Rev     : 1.0  initial release                                           |
// +------------------------------------------------------------------------+
package eth_pkg;

  // Receive FSM states.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_DATA     = 3'd2,
    ST_FLUSH    = 3'd3,
    ST_HOLD     = 3'd4,
    ST_DROP     = 3'd5
  } eth_state_e;

  localparam logic [7:0] SFD       = 8'hD5;
  localparam int         MIN_FRAME = 64;

  // Bit positions inside status = {runt, align, ovf, rxerr}.
  localparam int STAT_RXERR = 0;
  localparam int STAT_OVF   = 1;
  localparam int STAT_ALIGN = 2;
  localparam int STAT_RUNT  = 3;

endpackage : eth_pkg
`default_nettype wire

// File: rtl/eth_nib2byte.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : eth_nib2byte                                                   |
// | Purpose : Turns the PHY receive stream into bytes. In GMII mode every    |
// |           enabled cycle is a byte; in MII mode two enabled cycles make   |
// |           one byte, low nibble first.                                    |
// | Ports   : clk, rst      - clock, synchronous active-high reset           |
// |           clr           - force the nibble phase back to "low nibble"    |
// |                           for the current sample                         |
// |           en            - current rxd sample belongs to the stream       |
// |           gmii          - 1 = byte per clock, 0 = nibble on rxd[3:0]     |
// |           rxd           - PHY data                                       |
// |           byte_stb      - byte_out is a completed byte this cycle        |
// |           byte_out      - assembled byte                                 |
// |           nib_left      - a low nibble is held waiting for its partner   |
// | Rev     : 1.0  initial release                                           |
// +------------------------------------------------------------------------+
module eth_nib2byte (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       gmii,
  input  logic [7:0] rxd,
  output logic       byte_stb,
  output logic [7:0] byte_out,
  output logic       nib_left
);

  logic       phase_q, phase_d;
  logic [3:0] low_q,   low_d;
  logic       phase_eff;

  // The strobe is combinational so the packer can consume the byte on the
  // same clock edge that samples its last nibble.
  always_comb begin
    phase_eff = clr ? 1'b0 : phase_q;
    phase_d   = phase_eff;
    low_d     = low_q;
    byte_stb  = 1'b0;
    byte_out  = rxd;
    if (en) begin
      if (gmii) begin
        byte_stb = 1'b1;
        phase_d  = 1'b0;
      end else if (!phase_eff) begin
        low_d   = rxd[3:0];
        phase_d = 1'b1;
      end else begin
        byte_stb = 1'b1;
        byte_out = {rxd[3:0], low_q};
        phase_d  = 1'b0;
      end
    end
  end

  assign nib_left = phase_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= 1'b0;
      low_q   <= 4'h0;
    end else begin
      phase_q <= phase_d;
      low_q   <= low_d;
    end
  end

endmodule : eth_nib2byte
`default_nettype wire

// File: rtl/eth_rx_packer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : eth_rx_packer                                                  |
// | Purpose : Receives one Ethernet frame from a GMII/MII PHY, strips the    |
// |           preamble/SFD, packs bytes little-endian into DATA_W-bit words  |
// |           written to a buffer, and holds the byte count and status until |
// |           the consumer acknowledges with done.                           |
// | Ports   : clk, rst       - PHY rx clock, synchronous active-high reset   |
// |           gmii           - mode, sampled only while idle                 |
// |           rx_en          - accept new frames                             |
// |           rxdv/rxer/rxd  - PHY receive interface                         |
// |           done           - consumer has taken the held frame             |
// |           wr_en/wr_addr/wr_data - buffer write port                      |
// |           byte_cnt       - frame bytes after SFD (saturates)             |
// |           frame_rdy      - frame complete and held                       |
// |           status         - {runt, align, ovf, rxerr}                     |
// | Rev     : 1.0  initial release                                           |
// +------------------------------------------------------------------------+
module eth_rx_packer
  import eth_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 9,
  parameter int MAX_BYTES = 1536
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              gmii,
  input  logic              rx_en,
  input  logic              rxdv,
  input  logic              rxer,
  input  logic [7:0]        rxd,
  input  logic              done,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [10:0]       byte_cnt,
  output logic              frame_rdy,
  output logic [3:0]        status
);

  localparam int BPW    = DATA_W / 8;
  localparam int LANE_W = (BPW > 1) ? $clog2(BPW) : 1;

  eth_state_e        state_q,     state_d;
  logic              gmii_q,      gmii_d;
  logic [LANE_W-1:0] lane_q,      lane_d;
  logic [DATA_W-1:0] word_q,      word_d;
  logic              wr_en_q,     wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q,   wr_addr_d;
  logic [DATA_W-1:0] wr_data_q,   wr_data_d;
  logic [10:0]       byte_cnt_q,  byte_cnt_d;
  logic              frame_rdy_q, frame_rdy_d;
  logic [3:0]        status_q,    status_d;

  logic              nib_en;
  logic              nib_clr;
  logic              gmii_eff;
  logic              byte_stb;
  logic [7:0]        byte_out;
  logic              nib_left;
  logic [DATA_W-1:0] merged;

  // In IDLE the mode pin is live (it is being sampled this cycle); once a
  // frame starts the latched copy is used so mid-frame changes are ignored.
  assign gmii_eff = (state_q == ST_IDLE) ? gmii : gmii_q;

  // The IDLE cycle that starts a frame already carries the first preamble
  // nibble/byte, so it is fed to the assembler with the phase forced clear.
  assign nib_en  = rxdv && (((state_q == ST_IDLE) && rx_en) ||
                            (state_q == ST_PREAMBLE) || (state_q == ST_DATA));
  // FLUSH keeps the phase so a stray nibble is still visible for align.
  assign nib_clr = (state_q == ST_IDLE) || (state_q == ST_HOLD) ||
                   (state_q == ST_DROP);

  eth_nib2byte u_nib2byte (
    .clk      (clk),
    .rst      (rst),
    .clr      (nib_clr),
    .en       (nib_en),
    .gmii     (gmii_eff),
    .rxd      (rxd),
    .byte_stb (byte_stb),
    .byte_out (byte_out),
    .nib_left (nib_left)
  );

  // Current word with the incoming byte dropped into its lane. Lanes above
  // lane_q are always zero because word_q is cleared after every write.
  always_comb begin
    merged = word_q;
    for (int i = 0; i < BPW; i++) begin
      if (lane_q == LANE_W'(i)) begin
        merged[8*i +: 8] = byte_out;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    gmii_d      = gmii_q;
    lane_d      = lane_q;
    word_d      = word_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    byte_cnt_d  = byte_cnt_q;
    frame_rdy_d = frame_rdy_q;
    status_d    = status_q;

    // The address advances in the cycle after each write strobe.
    if (wr_en_q && ((state_q == ST_DATA) || (state_q == ST_FLUSH))) begin
      wr_addr_d = wr_addr_q + ADDR_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        gmii_d = gmii;
        if (rxdv) begin
          state_d = rx_en ? ST_PREAMBLE : ST_DROP;
        end
      end

      ST_PREAMBLE: begin
        if (!rxdv) begin
          state_d = ST_IDLE;
        end else if (byte_stb && (byte_out == SFD)) begin
          state_d    = ST_DATA;
          byte_cnt_d = 11'd0;
          wr_addr_d  = '0;
          status_d   = 4'h0;
          lane_d     = '0;
          word_d     = '0;
        end
      end

      ST_DATA: begin
        if (rxer) begin
          status_d[STAT_RXERR] = 1'b1;
        end
        if (!rxdv) begin
          state_d = ST_FLUSH;
          if (lane_q != '0) begin
            wr_en_d   = 1'b1;
            wr_data_d = word_q;
          end
        end else if (byte_stb) begin
          if (byte_cnt_q == 11'(MAX_BYTES)) begin
            status_d[STAT_OVF] = 1'b1;
          end else begin
            byte_cnt_d = byte_cnt_q + 11'd1;
            if (lane_q == LANE_W'(BPW - 1)) begin
              wr_en_d   = 1'b1;
              wr_data_d = merged;
              lane_d    = '0;
              word_d    = '0;
            end else begin
              lane_d = lane_q + LANE_W'(1);
              word_d = merged;
            end
          end
        end
      end

      ST_FLUSH: begin
        state_d               = ST_HOLD;
        frame_rdy_d           = 1'b1;
        status_d[STAT_ALIGN]  = nib_left && !gmii_q;
        status_d[STAT_RUNT]   = (byte_cnt_q < 11'(MIN_FRAME));
      end

      ST_HOLD: begin
        if (done) begin
          frame_rdy_d = 1'b0;
          state_d     = rxdv ? ST_DROP : ST_IDLE;
        end
      end

      ST_DROP: begin
        if (!rxdv) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      gmii_q      <= 1'b0;
      lane_q      <= '0;
      word_q      <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      byte_cnt_q  <= 11'd0;
      frame_rdy_q <= 1'b0;
      status_q    <= 4'h0;
    end else begin
      state_q     <= state_d;
      gmii_q      <= gmii_d;
      lane_q      <= lane_d;
      word_q      <= word_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      byte_cnt_q  <= byte_cnt_d;
      frame_rdy_q <= frame_rdy_d;
      status_q    <= status_d;
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign byte_cnt  = byte_cnt_q;
  assign frame_rdy = frame_rdy_q;
  assign status    = status_q;

endmodule : eth_rx_packer
`default_nettype wire
